// File: rtl/shift_add_multiplier.sv
// Sequential unsigned N x N shift-and-add multiplier built around one CLA_nbit adder.
// Optional macro ZERO_BYPASS_EN: a zero operand skips the iterations and completes in one cycle.

module CLA_nbit #(
  parameter int N = 4
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] Sum,
  output logic         Cout
);
  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;
  logic         acc;
  logic         prop;

  // Each carry is a flat sum of generate terms gated by the propagates above them.
  always_comb begin
    g    = A & B;
    p    = A ^ B;
    c    = '0;
    acc  = 1'b0;
    prop = 1'b0;
    c[0] = Cin;
    for (int i = 0; i < N; i++) begin
      acc  = g[i];
      prop = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc  = acc | (prop & g[j]);
        prop = prop & p[j];
      end
      c[i+1] = acc | (prop & Cin);
    end
    Sum  = p ^ c[N-1:0];
    Cout = c[N];
  end
endmodule

module shift_add_multiplier #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product,
  output logic [1:0]     dbg_state,
  output logic [2*N-1:0] dbg_p
);
  // Handshake: start is sampled only in IDLE; busy is high for the N iteration
  // cycles; done is a one-cycle pulse with product final; product holds until the
  // next accepted start.
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   m_q, m_d;
  logic [2*N-1:0] p_q, p_d;
  logic [2*N-1:0] product_q, product_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [N-1:0]   cla_sum;
  logic           cla_cout;
  logic [2*N-1:0] p_iter;
  logic           zero_op;

  CLA_nbit #(.N(N)) u_cla (
    .A    (p_q[2*N-1:N]),
    .B    (m_q),
    .Cin  (1'b0),
    .Sum  (cla_sum),
    .Cout (cla_cout)
  );

`ifdef ZERO_BYPASS_EN
  assign zero_op = (A == '0) || (B == '0);
`else
  assign zero_op = 1'b0;
`endif

  always_comb begin
    if (p_q[0]) p_iter = {cla_cout, cla_sum, p_q[N-1:1]};
    else        p_iter = {1'b0, p_q[2*N-1:N], p_q[N-1:1]};
  end

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    p_d       = p_q;
    product_d = product_q;
    cnt_d     = cnt_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d   = A;
          p_d   = {{N{1'b0}}, B};
          cnt_d = '0;
          if (zero_op) begin
            state_d   = DONE;
            product_d = '0;
            done_d    = 1'b1;
          end else begin
            state_d = BUSY;
            busy_d  = 1'b1;
          end
        end
      end
      BUSY: begin
        p_d   = p_iter;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d   = DONE;
          product_d = p_iter;
          done_d    = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      m_q       <= '0;
      p_q       <= '0;
      product_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      p_q       <= p_d;
      product_q <= product_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign product   = product_q;
  assign dbg_state = state_q;
  assign dbg_p     = p_q;
endmodule

// File: doc/shift_add_multiplier.md
# shift_add_multiplier

Sequential unsigned N×N multiplier that uses one `CLA_nbit` instance as its only adder and reuses it for N shift-and-add iterations. It sits directly downstream of `CLA_nbit`: it takes the adder's `Sum`/`Cout` every cycle and turns them into a registered 2N-bit product. A start/busy/done handshake makes it usable as an arithmetic unit by a controller.

## Interface
- `N`, default 4: operand width; also the iteration count. Legal for N ≥ 2.
- `clk`  input  1: rising-edge clock.
- `rst`  input  1: synchronous, active-high reset.
- `start`  input  1: request a multiply. Sampled only in IDLE.
- `A`  input  N: multiplicand, unsigned. Sampled on the accepting edge only.
- `B`  input  N: multiplier, unsigned. Sampled on the accepting edge only.
- `busy`  output  1: high in BUSY.
- `done`  output  1: one-cycle pulse; `product` is valid and final.
- `product`  output  2N: result register. Holds its value until the next accepted start.

## Operation
- FSM has three states: IDLE, BUSY and DONE, encoded in 2 bits.
  - IDLE→BUSY on `start`.
  - BUSY→DONE when the iteration counter reaches N−1 and the iteration completes.
  - DONE→IDLE unconditionally.
- Datapath registers:
  - `M` (N bits): latched multiplicand.
  - `P` (2N bits): `{upper, lower}` accumulator/shift register.
  - `cnt`: ⌈log2 N⌉+1 bits.
- Accept edge (IDLE and `start`):
  - `M` ← `A`.
  - `P` ← `{N'b0, B}`.
  - `cnt` ← 0.
  - `product` is not changed.
- BUSY iteration, one per cycle:
  - The CLA is fed `A=P[2N-1:N]` and `B=M`.
  - If `P[0]`=1: `P` ← `{Cout, Sum, P[N-1:1]}`.
  - Otherwise: `P` ← `{1'b0, P[2N-1:N], P[N-1:1]}`.
  - `cnt` increments.
- The CLA is always instantiated and evaluates every cycle. Its result is used only when `P[0]`=1.
- On the final iteration edge, `product` is written with the new `P` value.
- Widths:
  - `Cout` is always captured, so no bit is lost.
  - The product of two N-bit unsigned values never exceeds 2N bits, so no overflow flag is needed.
- `start` in BUSY or DONE is ignored. It is not queued.
- `A`/`B` changes after the accept edge have no effect.

## Timing
- Reset values:
  - state = IDLE.
  - `busy`=0, `done`=0.
  - `product`=0, `P`=0, `M`=0, `cnt`=0.
- Reset takes priority over every other action, including mid-BUSY. Reset aborts the operation, discards the partial result and clears `product` to 0.
- Accept edge is t0:
  - `busy` is high during cycles t0+1 … t0+N.
  - Iterations occur on edges t1 … tN.
  - `done`=1 and the new `product` are visible in the cycle after tN, which is N cycles after accept.
  - `done` is high for exactly one cycle. `busy` is 0 while `done` is 1.
- Earliest back-to-back operation: `start` held high is accepted on the first edge in IDLE after DONE. That gives a throughput of one product per N+2 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- Macro: `ZERO_BYPASS_EN`.
- When defined:
  - An accept edge with `A`==0 or `B`==0 goes straight IDLE→DONE.
  - `product` ← 0 on that edge.
  - `done` is asserted in the next cycle.
  - `busy` never rises.
  - Latency is 1 cycle. No CLA iterations are performed.
- When not defined: zero operands take the normal N-iteration path. Latency is N cycles and the result is 0.
- Non-zero operands behave identically in both builds.

## Test plan
All scenarios use N=4.
- A=15, B=15, 1-cycle `start` pulse → `busy` high for 4 cycles, then `done` pulses once with `product`=225. `product` still reads 225 ten cycles later.
- A=13, B=11 → `product`=143. The first iteration adds (B[0]=1) and the third skips (B[2]=0); check the `P` trace cycle by cycle.
- A=0, B=9 → without `ZERO_BYPASS_EN`: `done` 4 cycles after accept, `product`=0. With `ZERO_BYPASS_EN`: `done` 1 cycle after accept, `busy` stays 0, `product`=0.
- Accept A=6, B=7. Then, while BUSY, drive `start`=1 with A=2, B=2 → the second request is ignored; `product`=42 and only one `done` pulse occurs. With `start` still high, the next accept happens on the first IDLE edge and yields 4.
- Accept A=9, B=5, then assert `rst` for 1 cycle during the 2nd BUSY cycle → next cycle shows state IDLE, `busy`=0, `done`=0, `product`=0. A fresh A=3, B=4 then yields 12.
- 100 random operand pairs, each checked against the A×B reference → all match, with `done` exactly N cycles after every accept.
